// File: rtl/mem_access.sv
// mem_access: MEM stage of the five-stage RISC-V pipeline. Runs one data-bus
// transaction per load/store, stalls the front of the pipeline until the bus
// answers (or times out), then hands the extracted load result, or the
// pass-through ALU result, on to MEM/WB.
module mem_access #(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned TIMEOUT_CYC = 64
) (
    input  logic              clk_100M,
    input  logic              rst,
    input  logic              ram_r_ena_i,
    input  logic [ADDR_W-1:0] ram_r_addr_i,
    input  logic              ram_w_ena_i,
    input  logic [ADDR_W-1:0] ram_w_addr_i,
    input  logic [31:0]       ram_w_data_i,
    input  logic [31:0]       inst_i,
    input  logic              reg_w_ena_i,
    input  logic [4:0]        reg_w_addr_i,
    input  logic [31:0]       reg_w_data_i,
    output logic              bus_req_o,
    output logic              bus_we_o,
    output logic [ADDR_W-1:0] bus_addr_o,
    output logic [31:0]       bus_wdata_o,
    output logic [3:0]        bus_be_o,
    input  logic              bus_ack_i,
    input  logic [31:0]       bus_rdata_i,
    output logic              hold_o,
    output logic              exc_misalign_o,
    output logic              exc_bus_err_o,
    output logic              reg_w_ena_o,
    output logic [4:0]        reg_w_addr_o,
    output logic [31:0]       reg_w_data_o
);

    localparam int unsigned CntW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] { StIdle, StWait, StDone } state_e;
    typedef enum logic [1:0] { SzByte, SzHalf, SzWord } size_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d, cnt_inc;
    logic              bus_req_q, bus_req_d;
    logic              bus_we_q, bus_we_d;
    logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
    logic [31:0]       bus_wdata_q, bus_wdata_d;
    logic [3:0]        bus_be_q, bus_be_d;
    logic              bus_err_q, bus_err_d;
    logic              is_load_q, is_load_d;
    size_e             size_q, size_d;
    logic              uns_q, uns_d;
    logic [1:0]        off_q, off_d;
    logic [31:0]       rdata_q, rdata_d;

    logic              acc_load, acc_valid, acc_misalign, acc_unsigned;
    logic [ADDR_W-1:0] acc_addr;
    size_e             acc_size;
    logic [3:0]        acc_be;
    logic [31:0]       acc_wdata;
    logic [7:0]        ld_byte;
    logic [15:0]       ld_half;
    logic [31:0]       ld_data;

    // Only funct3 of the instruction matters here.
    logic unused_inst;
    assign unused_inst = ^{inst_i[31:15], inst_i[11:0]};

    // Decode the EX/MEM request; a load wins over a simultaneous store.
    always_comb begin
        acc_load  = ram_r_ena_i;
        acc_valid = ram_r_ena_i | ram_w_ena_i;
        acc_addr  = ram_r_ena_i ? ram_r_addr_i : ram_w_addr_i;
        case (inst_i[14:12])
            3'b000:  begin acc_size = SzByte; acc_unsigned = 1'b0; end
            3'b001:  begin acc_size = SzHalf; acc_unsigned = 1'b0; end
            3'b100:  begin acc_size = SzByte; acc_unsigned = 1'b1; end
            3'b101:  begin acc_size = SzHalf; acc_unsigned = 1'b1; end
            default: begin acc_size = SzWord; acc_unsigned = 1'b0; end
        endcase
        acc_misalign = acc_valid &
                       (((acc_size == SzHalf) & acc_addr[0]) |
                        ((acc_size == SzWord) & (acc_addr[1:0] != 2'b00)));
        acc_be    = 4'b1111;
        acc_wdata = 32'h0;
        if (!acc_load) begin
            case (acc_size)
                SzByte: begin
                    acc_be    = 4'b0001 << acc_addr[1:0];
                    acc_wdata = {4{ram_w_data_i[7:0]}};
                end
                SzHalf: begin
                    acc_be    = acc_addr[1] ? 4'b1100 : 4'b0011;
                    acc_wdata = {2{ram_w_data_i[15:0]}};
                end
                default: begin
                    acc_be    = 4'b1111;
                    acc_wdata = ram_w_data_i;
                end
            endcase
        end
    end

    // Pick the addressed lane out of the returned word and extend it.
    always_comb begin
        unique case (off_q)
            2'd0: ld_byte = bus_rdata_i[7:0];
            2'd1: ld_byte = bus_rdata_i[15:8];
            2'd2: ld_byte = bus_rdata_i[23:16];
            2'd3: ld_byte = bus_rdata_i[31:24];
        endcase
        ld_half = off_q[1] ? bus_rdata_i[31:16] : bus_rdata_i[15:0];
        case (size_q)
            SzByte:  ld_data = {{24{ld_byte[7] & ~uns_q}}, ld_byte};
            SzHalf:  ld_data = {{16{ld_half[15] & ~uns_q}}, ld_half};
            default: ld_data = bus_rdata_i;
        endcase
    end

    // Next-state logic: issue, wait for ack or timeout, then one result cycle.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        bus_be_d    = bus_be_q;
        bus_err_d   = 1'b0;
        is_load_d   = is_load_q;
        size_d      = size_q;
        uns_d       = uns_q;
        off_d       = off_q;
        rdata_d     = rdata_q;
        cnt_inc     = cnt_q + CntW'(1);
        unique case (state_q)
            StIdle: begin
                if (acc_valid && !acc_misalign) begin
                    state_d     = StWait;
                    cnt_d       = '0;
                    bus_req_d   = 1'b1;
                    bus_we_d    = ~acc_load;
                    bus_addr_d  = {acc_addr[ADDR_W-1:2], 2'b00};
                    bus_wdata_d = acc_wdata;
                    bus_be_d    = acc_be;
                    is_load_d   = acc_load;
                    size_d      = acc_size;
                    uns_d       = acc_unsigned;
                    off_d       = acc_addr[1:0];
                end
            end
            StWait: begin
                // An ack on the same edge as the timeout still completes normally.
                if (bus_ack_i) begin
                    rdata_d   = ld_data;
                    bus_req_d = 1'b0;
                    state_d   = StDone;
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == CntW'(TIMEOUT_CYC)) begin
                        bus_req_d = 1'b0;
                        bus_err_d = 1'b1;
                        rdata_d   = 32'h0;
                        state_d   = StDone;
                    end
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // State and registered bus outputs, synchronous reset.
    always_ff @(posedge clk_100M) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_wdata_q <= 32'h0;
            bus_be_q    <= 4'h0;
            bus_err_q   <= 1'b0;
            is_load_q   <= 1'b0;
            size_q      <= SzWord;
            uns_q       <= 1'b0;
            off_q       <= 2'd0;
            rdata_q     <= 32'h0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            bus_be_q    <= bus_be_d;
            bus_err_q   <= bus_err_d;
            is_load_q   <= is_load_d;
            size_q      <= size_d;
            uns_q       <= uns_d;
            off_q       <= off_d;
            rdata_q     <= rdata_d;
        end
    end

    assign bus_req_o     = bus_req_q;
    assign bus_we_o      = bus_we_q;
    assign bus_addr_o    = bus_addr_q;
    assign bus_wdata_o   = bus_wdata_q;
    assign bus_be_o      = bus_be_q;
    assign exc_bus_err_o = bus_err_q;

    // Stall, misalignment flag and writeback; all held at zero during reset.
    always_comb begin
        hold_o         = 1'b0;
        exc_misalign_o = 1'b0;
        reg_w_ena_o    = reg_w_ena_i;
        reg_w_addr_o   = reg_w_addr_i;
        reg_w_data_o   = reg_w_data_i;
        if (rst) begin
            reg_w_ena_o  = 1'b0;
            reg_w_addr_o = 5'd0;
            reg_w_data_o = 32'h0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (acc_misalign) begin
                        exc_misalign_o = 1'b1;
                        reg_w_ena_o    = 1'b0;
                    end else if (acc_valid) begin
                        hold_o      = 1'b1;
                        reg_w_ena_o = 1'b0;
                    end
                end
                StWait: begin
                    hold_o      = 1'b1;
                    reg_w_ena_o = 1'b0;
                end
                StDone: begin
                    reg_w_ena_o = is_load_q & ~bus_err_q;
                    if (is_load_q) begin
                        reg_w_data_o = rdata_q;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access: drives loads, stores and ALU pass-through cycles into
// mem_access while acting as the bus slave, and checks every cycle against a
// transaction-level model of the MEM stage.
module tb_mem_access;

    localparam int unsigned AW = 32;
    localparam int unsigned TO = 4;

    logic          clk_100M = 1'b0;
    logic          rst;
    logic          ram_r_ena_i, ram_w_ena_i;
    logic [AW-1:0] ram_r_addr_i, ram_w_addr_i;
    logic [31:0]   ram_w_data_i, inst_i;
    logic          reg_w_ena_i;
    logic [4:0]    reg_w_addr_i;
    logic [31:0]   reg_w_data_i;
    logic          bus_req_o, bus_we_o;
    logic [AW-1:0] bus_addr_o;
    logic [31:0]   bus_wdata_o;
    logic [3:0]    bus_be_o;
    logic          bus_ack_i;
    logic [31:0]   bus_rdata_i;
    logic          hold_o, exc_misalign_o, exc_bus_err_o;
    logic          reg_w_ena_o;
    logic [4:0]    reg_w_addr_o;
    logic [31:0]   reg_w_data_o;

    mem_access #(.ADDR_W(AW), .TIMEOUT_CYC(TO)) dut (
        .clk_100M      (clk_100M),
        .rst           (rst),
        .ram_r_ena_i   (ram_r_ena_i),
        .ram_r_addr_i  (ram_r_addr_i),
        .ram_w_ena_i   (ram_w_ena_i),
        .ram_w_addr_i  (ram_w_addr_i),
        .ram_w_data_i  (ram_w_data_i),
        .inst_i        (inst_i),
        .reg_w_ena_i   (reg_w_ena_i),
        .reg_w_addr_i  (reg_w_addr_i),
        .reg_w_data_i  (reg_w_data_i),
        .bus_req_o     (bus_req_o),
        .bus_we_o      (bus_we_o),
        .bus_addr_o    (bus_addr_o),
        .bus_wdata_o   (bus_wdata_o),
        .bus_be_o      (bus_be_o),
        .bus_ack_i     (bus_ack_i),
        .bus_rdata_i   (bus_rdata_i),
        .hold_o        (hold_o),
        .exc_misalign_o(exc_misalign_o),
        .exc_bus_err_o (exc_bus_err_o),
        .reg_w_ena_o   (reg_w_ena_o),
        .reg_w_addr_o  (reg_w_addr_o),
        .reg_w_data_o  (reg_w_data_o)
    );

    always #5 clk_100M = ~clk_100M;

    int n_checks = 0;
    int n_fail   = 0;
    int hold_run = 0;

    // Expected outputs for the current cycle, set by the driver.
    bit          chk_en, chk_bus, chk_bwd, chk_wb, chk_wdat;
    logic        e_hold, e_mis, e_req, e_err, e_we, e_wena;
    logic [31:0] e_addr, e_bwd, e_wbd;
    logic [3:0]  e_be;
    logic [4:0]  e_wba;

    // Hand-computed values for directed transactions.
    bit          lit_arm, lit_bus, lit_done, l_bwd_on, l_wbd_on;
    logic [31:0] l_addr, l_bwd, l_wbd;
    logic [3:0]  l_be;
    logic        l_we;
    int          l_hold;

    // ---------------- model ----------------
    function automatic int size_of(input logic [2:0] f3);
        case (f3)
            3'b000, 3'b100: return 1;
            3'b001, 3'b101: return 2;
            default:        return 4;
        endcase
    endfunction

    function automatic logic [3:0] be_of(input bit ld, input int sz, input int off);
        logic [31:0] m;
        if (ld) return 4'hF;
        m = ((32'd1 << sz) - 32'd1) << off;
        return m[3:0];
    endfunction

    function automatic logic [31:0] wd_of(input int sz, input logic [31:0] d);
        if (sz == 1) return 32'(d[7:0]) * 32'h0101_0101;
        if (sz == 2) return 32'(d[15:0]) * 32'h0001_0001;
        return d;
    endfunction

    function automatic logic [31:0] ld_of(input logic [31:0] rdata, input int off,
                                          input logic [2:0] f3);
        int          sz;
        logic [31:0] v, mask;
        sz = size_of(f3);
        if (sz == 4) return rdata;
        v    = rdata >> (8 * off);
        mask = (32'd1 << (8 * sz)) - 32'd1;
        v    = v & mask;
        if (f3[2] == 1'b0 && v[8 * sz - 1]) v = v | ~mask;
        return v;
    endfunction

    // ---------------- compare ----------------
    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk_100M) begin
        if (chk_en) begin
            cmp("hold_o", 32'(hold_o), 32'(e_hold));
            cmp("exc_misalign_o", 32'(exc_misalign_o), 32'(e_mis));
            cmp("bus_req_o", 32'(bus_req_o), 32'(e_req));
            cmp("exc_bus_err_o", 32'(exc_bus_err_o), 32'(e_err));
            if (chk_bus) begin
                cmp("bus_we_o", 32'(bus_we_o), 32'(e_we));
                cmp("bus_addr_o", bus_addr_o, e_addr);
                cmp("bus_be_o", 32'(bus_be_o), 32'(e_be));
                if (chk_bwd) cmp("bus_wdata_o", bus_wdata_o, e_bwd);
            end
            if (chk_wb) begin
                cmp("reg_w_ena_o", 32'(reg_w_ena_o), 32'(e_wena));
                if (chk_wdat) begin
                    cmp("reg_w_addr_o", 32'(reg_w_addr_o), 32'(e_wba));
                    cmp("reg_w_data_o", reg_w_data_o, e_wbd);
                end
            end
            if (lit_bus) begin
                cmp("lit bus_addr_o", bus_addr_o, l_addr);
                cmp("lit bus_be_o", 32'(bus_be_o), 32'(l_be));
                cmp("lit bus_we_o", 32'(bus_we_o), 32'(l_we));
                if (l_bwd_on) cmp("lit bus_wdata_o", bus_wdata_o, l_bwd);
            end
            if (lit_done) begin
                cmp("lit hold cycles", 32'(hold_run), 32'(l_hold));
                if (l_wbd_on) cmp("lit reg_w_data_o", reg_w_data_o, l_wbd);
            end
        end
        hold_run = (hold_o === 1'b1) ? hold_run + 1 : 0;
    end

    // ---------------- driver ----------------
    task automatic step();
        @(posedge clk_100M);
        #1;
    endtask

    task automatic clr_exp();
        chk_en = 0; chk_bus = 0; chk_bwd = 0; chk_wb = 0; chk_wdat = 0;
        e_hold = 0; e_mis = 0; e_req = 0; e_err = 0; e_we = 0; e_wena = 0;
        e_addr = '0; e_bwd = '0; e_wbd = '0; e_be = '0; e_wba = '0;
        lit_bus = 0; lit_done = 0;
    endtask

    task automatic arm(input logic [31:0] addr, input logic [3:0] be, input logic we,
                       input bit bwd_on, input logic [31:0] bwd, input int hold,
                       input bit wbd_on, input logic [31:0] wbd);
        lit_arm = 1; l_addr = addr; l_be = be; l_we = we; l_bwd_on = bwd_on; l_bwd = bwd;
        l_hold = hold; l_wbd_on = wbd_on; l_wbd = wbd;
    endtask

    // One cycle of a non-memory instruction.
    task automatic run_alu(input logic ena, input logic [4:0] wa, input logic [31:0] wd);
        ram_r_ena_i  = 0;
        ram_w_ena_i  = 0;
        ram_r_addr_i = $urandom;
        ram_w_addr_i = $urandom;
        ram_w_data_i = $urandom;
        inst_i       = $urandom;
        reg_w_ena_i  = ena;
        reg_w_addr_i = wa;
        reg_w_data_i = wd;
        bus_ack_i    = 1'($urandom);
        bus_rdata_i  = $urandom;
        clr_exp();
        chk_en = 1; chk_wb = 1; chk_wdat = 1;
        e_wena = ena; e_wba = wa; e_wbd = wd;
        lit_done = lit_arm;
        step();
        lit_arm = 0;
    endtask

    // One load/store; ack_dly >= TO means the bus never answers.
    task automatic run_access(input bit ld, input bit both, input logic [31:0] addr,
                              input logic [2:0] f3, input logic [31:0] sdata,
                              input logic [31:0] rdata, input int ack_dly);
        int          sz, off, w;
        bit          tmo;
        logic [4:0]  rd;
        logic [31:0] ins;
        sz  = size_of(f3);
        off = int'(addr[1:0]);
        rd  = 5'($urandom);
        ins = $urandom;
        ins[14:12]   = f3;
        ram_r_ena_i  = ld;
        ram_w_ena_i  = !ld || both;
        ram_r_addr_i = ld ? addr : $urandom;
        ram_w_addr_i = ld ? $urandom : addr;
        ram_w_data_i = sdata;
        inst_i       = ins;
        reg_w_ena_i  = 1'($urandom);
        reg_w_addr_i = rd;
        reg_w_data_i = $urandom;
        if ((off % sz) != 0) begin
            clr_exp();
            chk_en = 1; e_mis = 1; chk_wb = 1; e_wena = 0;
            bus_ack_i   = 1'($urandom);
            bus_rdata_i = $urandom;
            step();
            lit_arm = 0;
            return;
        end
        tmo = (ack_dly >= int'(TO));
        w   = tmo ? int'(TO) : ack_dly + 1;
        for (int k = 0; k <= w + 1; k++) begin
            clr_exp();
            chk_en      = 1;
            bus_ack_i   = 0;
            bus_rdata_i = $urandom;
            if (k == 0) begin
                e_hold    = 1;
                bus_ack_i = 1'($urandom);
            end else if (k <= w) begin
                e_hold  = 1;
                e_req   = 1;
                chk_bus = 1;
                e_we    = !ld;
                e_addr  = addr & ~32'd3;
                e_be    = be_of(ld, sz, off);
                chk_bwd = !ld;
                e_bwd   = wd_of(sz, sdata);
                lit_bus = lit_arm;
                if (!tmo && k == ack_dly + 1) begin
                    bus_ack_i   = 1;
                    bus_rdata_i = rdata;
                end
            end else begin
                e_err     = tmo;
                chk_wb    = 1;
                e_wena    = ld && !tmo;
                chk_wdat  = ld;
                e_wba     = rd;
                e_wbd     = tmo ? 32'h0 : ld_of(rdata, off, f3);
                lit_done  = lit_arm;
                bus_ack_i = 1'($urandom);
            end
            step();
        end
        lit_arm = 0;
    endtask

    // ---------------- stimulus ----------------
    int          kind, dly;
    logic [2:0]  rf3;
    logic [31:0] raddr;

    initial begin
        rst = 1;
        ram_r_ena_i = 0; ram_w_ena_i = 0; ram_r_addr_i = '0; ram_w_addr_i = '0;
        ram_w_data_i = '0; inst_i = '0; reg_w_ena_i = 0; reg_w_addr_i = '0;
        reg_w_data_i = '0; bus_ack_i = 0; bus_rdata_i = '0;
        lit_arm = 0;
        clr_exp();
        step();
        step();

        // Reset state, with a live ALU result presented at the inputs.
        reg_w_ena_i = 1; reg_w_addr_i = 5'h1f; reg_w_data_i = 32'hCAFE_F00D;
        clr_exp();
        chk_en = 1; chk_bus = 1; chk_bwd = 1; chk_wb = 1; chk_wdat = 1;
        step();
        rst = 0;

        // LW, ack two cycles after the request.
        arm(32'h100, 4'hF, 1'b0, 0, 32'h0, 4, 1, 32'hDEAD_BEEF);
        run_access(1, 0, 32'h100, 3'b010, 32'h0, 32'hDEAD_BEEF, 2);
        // LB / LBU / LHU from the same word.
        arm(32'h200, 4'hF, 1'b0, 0, 32'h0, 3, 1, 32'hFFFF_FF80);
        run_access(1, 0, 32'h203, 3'b000, 32'h0, 32'h8011_2233, 1);
        arm(32'h200, 4'hF, 1'b0, 0, 32'h0, 3, 1, 32'h0000_0080);
        run_access(1, 0, 32'h203, 3'b100, 32'h0, 32'h8011_2233, 1);
        arm(32'h200, 4'hF, 1'b0, 0, 32'h0, 3, 1, 32'h0000_8011);
        run_access(1, 0, 32'h202, 3'b101, 32'h0, 32'h8011_2233, 1);
        // SH with immediate ack.
        arm(32'h304, 4'b1100, 1'b1, 1, 32'hABCD_ABCD, 2, 0, 32'h0);
        run_access(0, 0, 32'h306, 3'b001, 32'h0000_ABCD, 32'h0, 0);
        // SB to the top lane.
        arm(32'h508, 4'b1000, 1'b1, 1, 32'hA5A5_A5A5, 3, 0, 32'h0);
        run_access(0, 0, 32'h50B, 3'b000, 32'h1234_56A5, 32'h0, 1);
        // Misaligned LW and SH.
        run_access(1, 0, 32'h101, 3'b010, 32'h0, 32'h0, 0);
        run_access(0, 0, 32'h303, 3'b001, 32'h0, 32'h0, 0);
        // Never-acked load times out after TO wait cycles.
        arm(32'h400, 4'hF, 1'b0, 0, 32'h0, 5, 1, 32'h0);
        run_access(1, 0, 32'h400, 3'b010, 32'h0, 32'h1111_1111, 99);
        // Ack on the last wait cycle beats the timeout.
        arm(32'h404, 4'hF, 1'b0, 0, 32'h0, 5, 1, 32'h1234_5678);
        run_access(1, 0, 32'h404, 3'b010, 32'h0, 32'h1234_5678, int'(TO) - 1);
        // Load and store requested together: the load wins.
        arm(32'h408, 4'hF, 1'b0, 0, 32'h0, 2, 1, 32'h0A0B_0C0D);
        run_access(1, 1, 32'h408, 3'b010, 32'h0BAD_F00D, 32'h0A0B_0C0D, 0);

        // Reset lands in the second wait cycle of an unacked load.
        ram_r_ena_i = 1; ram_w_ena_i = 0; ram_r_addr_i = 32'h500;
        inst_i = 32'h0000_2003; reg_w_ena_i = 1; reg_w_addr_i = 5'd3; bus_ack_i = 0;
        clr_exp(); chk_en = 1; e_hold = 1;
        step();
        clr_exp(); chk_en = 1; e_hold = 1; e_req = 1;
        step();
        rst = 1;
        clr_exp(); chk_en = 1; e_req = 1;
        step();
        rst = 0;
        arm(32'h0, 4'h0, 1'b0, 0, 32'h0, 0, 1, 32'h55);
        run_alu(1, 5'd7, 32'h55);
        run_alu(1'($urandom), 5'($urandom), $urandom);

        // Random mix of ALU, load and store traffic.
        for (int i = 0; i < 400; i++) begin
            kind  = $urandom_range(0, 9);
            rf3   = 3'($urandom);
            raddr = $urandom;
            if ($urandom_range(0, 3) != 0) raddr = raddr & ~32'(size_of(rf3) - 1);
            dly = $urandom_range(0, int'(TO) + 1);
            if (kind < 2) run_alu(1'($urandom), 5'($urandom), $urandom);
            else run_access(kind < 6, kind == 5, raddr, rf3, $urandom, $urandom, dly);
        end

        clr_exp();
        step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_access.md
# mem_access

Memory-access (MEM) stage of the five-stage RISC-V pipeline. Consumes the registered EX/MEM bundle (load/store request, instruction, pending register write) and runs the data-bus transaction. Holds the pipeline until the bus acknowledges, then presents the aligned, sign/zero-extended load result (or the pass-through ALU result) to MEM/WB. Also flags misaligned accesses and bus timeouts to the control unit.

## Interface

- ADDR_W, 32, address width
- TIMEOUT_CYC, 64, wait cycles without `bus_ack_i` before abort (≥2)
- clk_100M  in  1  system clock
- rst  in  1  synchronous, active-high reset
- ram_r_ena_i  in  1  load request from EX/MEM
- ram_r_addr_i  in  ADDR_W  load byte address
- ram_w_ena_i  in  1  store request from EX/MEM
- ram_w_addr_i  in  ADDR_W  store byte address
- ram_w_data_i  in  32  store data (rs2)
- inst_i  in  32  instruction; funct3 = inst_i[14:12]
- reg_w_ena_i / reg_w_addr_i / reg_w_data_i  in  1/5/32  pending writeback from EX
- bus_req_o  out  1  bus request, registered
- bus_we_o  out  1  1 = store, registered
- bus_addr_o  out  ADDR_W  word-aligned address ({addr[ADDR_W-1:2],2'b00}), registered
- bus_wdata_o  out  32  lane-replicated store data, registered
- bus_be_o  out  4  byte enables, registered
- bus_ack_i  in  1  one-cycle completion strobe
- bus_rdata_i  in  32  read word, valid with `bus_ack_i`
- hold_o  out  1  stall request to ctrl (freezes PC…EX/MEM)
- exc_misalign_o  out  1  misaligned access detected
- exc_bus_err_o  out  1  one-cycle pulse on timeout abort
- reg_w_ena_o / reg_w_addr_o / reg_w_data_o  out  1/5/32  writeback to MEM/WB

## Operation

- States: IDLE, WAIT, DONE. Reset → IDLE.
- Access present in IDLE: ram_r_ena_i (load, priority) else ram_w_ena_i (store). Both high → load only.
- Size from funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU; any other code → word.
- Misaligned: H/HU with addr[0]=1; W with addr[1:0]≠0. Then no bus access, exc_misalign_o=1 (combinational, IDLE only), reg_w_ena_o=0, hold_o=0, stay IDLE.
- Aligned access in IDLE: hold_o=1 (combinational), next edge: bus_* loaded, bus_req_o=1, timeout counter cleared, → WAIT.
- Store lanes: SB be=4'b0001<<addr[1:0], wdata={4{d[7:0]}}; SH be=addr[1]?4'b1100:4'b0011, wdata={2{d[15:0]}}; SW be=4'b1111. Load be=4'b1111, bus_we_o=0.
- WAIT: hold_o=1, bus_req_o held with stable addr/data. On bus_ack_i: capture extracted load data, bus_req_o←0, → DONE. Counter increments each WAIT cycle without ack; reaching TIMEOUT_CYC → bus_req_o←0, exc_bus_err_o pulses next cycle, load data forced 0, → DONE with write suppressed.
- Load extraction: byte lane addr[1:0], half lane addr[1]; B/H sign-extend, BU/HU zero-extend, W unmodified.
- DONE: hold_o=0; loads: reg_w_ena_o=1 (0 after timeout), reg_w_addr_o=reg_w_addr_i, reg_w_data_o=captured data; stores: reg_w_ena_o=0. → IDLE unconditionally (EX/MEM still shows the finished instruction this cycle; it is never reissued).
- IDLE, no access: reg_w_* = reg_w_*_i pass-through, hold_o=0.

## Timing

- Reset values: bus_req_o 0, bus_we_o 0, bus_addr_o 0, bus_wdata_o 0, bus_be_o 0, exc_bus_err_o 0, hold_o 0, exc_misalign_o 0, reg_w_ena_o 0, reg_w_addr_o 0, reg_w_data_o 0, state IDLE, counter 0.
- Access with ack N cycles after bus_req_o rises (N≥0, ack same edge allowed): hold_o high for N+2 cycles; result on reg_w_* in DONE, N+2 cycles after the access appears.
- Minimum back-to-back: one access per 3 cycles (IDLE, WAIT, DONE).
- bus_ack_i ignored in IDLE and DONE.
- rst mid-WAIT: next edge all outputs to reset values, IDLE; no pulses generated.
- Timeout on the same edge as ack: ack wins.

## Test plan

- LW addr 0x100, ack after 2 cycles, rdata 0xDEADBEEF → bus_addr_o 0x100, be 1111, hold_o 4 cycles, DONE reg_w_data_o 0xDEADBEEF, reg_w_ena_o 1.
- LB addr 0x203, rdata 0x80112233 → bus_addr_o 0x200, reg_w_data_o 0xFFFFFF80; LBU same → 0x00000080; LHU addr 0x202 → 0x00008011.
- SH addr 0x306, data 0x0000ABCD, immediate ack → bus_we_o 1, be 1100, wdata 0xABCDABCD, reg_w_ena_o 0 in DONE.
- LW addr 0x101 → exc_misalign_o 1, no bus_req_o, hold_o 0, reg_w_ena_o 0.
- TIMEOUT_CYC=4, load never acked → bus_req_o drops after 4 WAIT cycles, exc_bus_err_o one-cycle pulse, reg_w_ena_o 0 in DONE, back to IDLE.
- rst asserted in 2nd WAIT cycle → next cycle bus_req_o 0, hold_o 0, IDLE; ALU instruction (reg_w_data_i 0x55) afterwards passes through unchanged.
